// File: rtl/tb_axi_types_pkg.sv
// Shared AXI4 burst types plus the constants and helpers used by the
// per-beat address generator.
package tb_axi_types_pkg;

   typedef logic [7:0] axi_burst_length;
   typedef logic [2:0] axi_burst_size;

   typedef enum logic [1:0] {
      AXI_BURST_FIXED = 2'b00,
      AXI_BURST_INCR  = 2'b01,
      AXI_BURST_WRAP  = 2'b10,
      AXI_BURST_RSVD  = 2'b11
   } axi_burst_type;

   localparam int AXI_4KB_SHIFT     = 12;
   localparam int AXI_MAX_FIXED_LEN = 15;

   typedef enum logic {
      AGEN_IDLE,
      AGEN_BURST
   } agen_state_e;

   // WRAP bursts must be 2, 4, 8 or 16 beats long.
   function automatic logic axi_wrap_len_legal(input axi_burst_length len);
      return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
   endfunction

endpackage

// File: rtl/axi_burst_addr_gen_if.sv
// Request and beat-descriptor channels of the burst address generator.
interface axi_burst_addr_gen_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 64,
   parameter int ID_WIDTH   = 4
);
   logic                               req_valid_i;
   logic                               req_ready_o;
   logic [ID_WIDTH-1:0]                req_id_i;
   logic [ADDR_WIDTH-1:0]              req_addr_i;
   tb_axi_types_pkg::axi_burst_length  req_len_i;
   tb_axi_types_pkg::axi_burst_size    req_size_i;
   tb_axi_types_pkg::axi_burst_type    req_burst_i;

   logic                               beat_valid_o;
   logic                               beat_ready_i;
   logic [ID_WIDTH-1:0]                beat_id_o;
   logic [ADDR_WIDTH-1:0]              beat_addr_o;
   logic [7:0]                         beat_idx_o;
   logic [DATA_WIDTH/8-1:0]            beat_strb_o;
   logic                               beat_last_o;
   logic                               beat_err_o;

   // Requester side: issues AW/AR requests and consumes beats.
   modport master (
      output req_valid_i, req_id_i, req_addr_i, req_len_i, req_size_i, req_burst_i,
      output beat_ready_i,
      input  req_ready_o,
      input  beat_valid_o, beat_id_o, beat_addr_o, beat_idx_o, beat_strb_o,
      input  beat_last_o, beat_err_o
   );

   // Generator side.
   modport slave (
      input  req_valid_i, req_id_i, req_addr_i, req_len_i, req_size_i, req_burst_i,
      input  beat_ready_i,
      output req_ready_o,
      output beat_valid_o, beat_id_o, beat_addr_o, beat_idx_o, beat_strb_o,
      output beat_last_o, beat_err_o
   );
endinterface

// File: rtl/axi_burst_addr_gen_strb.sv
// Byte-lane strobe for one beat: lanes from the address offset up to the end
// of the size-aligned container that holds it.
module axi_strb_gen
   import tb_axi_types_pkg::*;
#(
   parameter  int DATA_WIDTH = 64,
   localparam int STRB_W     = DATA_WIDTH / 8,
   localparam int OFF_W      = (STRB_W > 1) ? $clog2(STRB_W) : 1
) (
   input  logic [OFF_W-1:0]  addr,
   input  axi_burst_size     size,
   output logic [STRB_W-1:0] strb
);
   logic [7:0] lo;
   logic [7:0] nbytes;
   logic [8:0] hi;

   assign lo     = 8'(addr);
   assign nbytes = 8'd1 << size;
   assign hi     = 9'(lo & ~(nbytes - 8'd1)) + 9'(nbytes);

   for (genvar i = 0; i < STRB_W; i++) begin : g_lane
      assign strb[i] = (9'(i) >= {1'b0, lo}) && (9'(i) < hi);
   end
endmodule

// File: rtl/axi_burst_addr_gen.sv
// Per-beat address/strobe generator for AXI4 FIXED, INCR and WRAP bursts,
// with AXI4 legality checking. Illegal bursts still emit len+1 beats.
module axi_burst_addr_gen
   import tb_axi_types_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 64,
   parameter int ID_WIDTH   = 4
) (
   input logic                 clk_i,
   input logic                 rst_i,
   axi_burst_addr_gen_if.slave bus
);
   localparam int STRB_W = DATA_WIDTH / 8;
   localparam int OFF_W  = (STRB_W > 1) ? $clog2(STRB_W) : 1;
   localparam int PG     = AXI_4KB_SHIFT;

   typedef logic [ADDR_WIDTH-1:0] addr_t;

   agen_state_e         state, state_nxt;
   logic [ID_WIDTH-1:0] id_q;
   addr_t               addr_q, lower_q, upper_q;
   axi_burst_length     len_q, idx_q;
   axi_burst_size       size_q;
   axi_burst_type       burst_q;
   logic                err_q;

   logic                beat_valid, last, req_ready, req_hs, beat_hs;
   addr_t               req_nbytes, req_aligned, req_total, req_lower, req_end;
   logic                req_err;
   addr_t               nbytes, next_incr, next_addr;
   logic [STRB_W-1:0]   strb_raw;

   // Burst parameters of the incoming request.
   assign req_nbytes  = addr_t'(1) << bus.req_size_i;
   assign req_aligned = bus.req_addr_i & ~(req_nbytes - addr_t'(1));
   assign req_total   = addr_t'({1'b0, bus.req_len_i} + 9'd1) << bus.req_size_i;
   assign req_lower   = bus.req_addr_i & ~(req_total - addr_t'(1));
   assign req_end     = req_aligned + (addr_t'(bus.req_len_i) << bus.req_size_i);

   // Legality check of the incoming request.
   always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      req_err = 1'b0;
      if (req_nbytes > addr_t'(STRB_W)) req_err = 1'b1;
      case (bus.req_burst_i)
         AXI_BURST_FIXED: if (bus.req_len_i > 8'(AXI_MAX_FIXED_LEN)) req_err = 1'b1;
         AXI_BURST_WRAP:  if (!axi_wrap_len_legal(bus.req_len_i) ||
                              (bus.req_addr_i != req_aligned)) req_err = 1'b1;
         AXI_BURST_INCR:  if (bus.req_addr_i[ADDR_WIDTH-1:PG] != req_end[ADDR_WIDTH-1:PG])
                              req_err = 1'b1;
         default:         req_err = 1'b1;
      endcase
   end

   // Address of the beat following the one currently presented.
   assign nbytes    = addr_t'(1) << size_q;
   assign next_incr = (addr_q & ~(nbytes - addr_t'(1))) + nbytes;

   // Burst-type specific address step.
   always_comb begin
      next_addr = next_incr;
      case (burst_q)
         AXI_BURST_FIXED: next_addr = addr_q;
         AXI_BURST_WRAP:  if (next_incr == upper_q) next_addr = lower_q;
         default:         next_addr = next_incr;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk_i) begin
      // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
      if (rst_i) state <= AGEN_IDLE;
      else       state <= state_nxt;
   end

   // FSM next state: a new request on the last-beat handshake keeps us in BURST.
   always_comb begin
      state_nxt = state;
      case (state)
         AGEN_IDLE:  if (req_hs) state_nxt = AGEN_BURST;
         AGEN_BURST: if (beat_hs && last && !req_hs) state_nxt = AGEN_IDLE;
         default:    state_nxt = AGEN_IDLE;
      endcase
   end

   // FSM outputs; ready reopens combinationally on the last-beat handshake.
   always_comb begin
      beat_valid = (state == AGEN_BURST);
      last       = beat_valid && (idx_q == len_q);
      req_ready  = !beat_valid || (bus.beat_ready_i && last);
   end

   assign req_hs  = bus.req_valid_i && req_ready;
   assign beat_hs = beat_valid && bus.beat_ready_i;

   // Burst context: loaded on request handshake, advanced on beat handshake.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         id_q    <= '0;
         addr_q  <= '0;
         lower_q <= '0;
         upper_q <= '0;
         len_q   <= '0;
         idx_q   <= '0;
         size_q  <= '0;
         burst_q <= AXI_BURST_FIXED;
         err_q   <= 1'b0;
      end else if (req_hs) begin
         id_q    <= bus.req_id_i;
         addr_q  <= bus.req_addr_i;
         lower_q <= req_lower;
         upper_q <= req_lower + req_total;
         len_q   <= bus.req_len_i;
         idx_q   <= '0;
         size_q  <= bus.req_size_i;
         burst_q <= bus.req_burst_i;
         err_q   <= req_err;
      end else if (beat_hs) begin
         idx_q   <= idx_q + 8'd1;
         addr_q  <= next_addr;
      end
   end

   axi_strb_gen #(.DATA_WIDTH(DATA_WIDTH)) u_strb (
      .addr (addr_q[OFF_W-1:0]),
      .size (size_q),
      .strb (strb_raw)
   );

   assign bus.req_ready_o  = req_ready;
   assign bus.beat_valid_o = beat_valid;
   assign bus.beat_id_o    = id_q;
   assign bus.beat_addr_o  = addr_q;
   assign bus.beat_idx_o   = idx_q;
   assign bus.beat_last_o  = last;
   assign bus.beat_err_o   = err_q;
   assign bus.beat_strb_o  = (beat_valid && !err_q) ? strb_raw : '0;
endmodule

// File: tb/tb_axi_burst_addr_gen.sv
// Randomized self-checking bench for axi_burst_addr_gen with a closed-form
// per-beat reference model, plus directed bursts with literal expectations.
module tb_axi_burst_addr_gen;
   import tb_axi_types_pkg::*;

   localparam int AW = 32;
   localparam int DW = 64;
   localparam int IW = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   axi_burst_addr_gen_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

   axi_burst_addr_gen #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   typedef struct {
      bit [31:0] addr;
      int        len;
      int        size;
      int        burst;
      bit [3:0]  id;
   } req_t;

   typedef struct {
      bit [31:0] addr;
      int        idx;
      bit [7:0]  strb;
      bit        last;
      bit        err;
      bit [3:0]  id;
      bit        addr_chk;
      int        cyc;
   } beat_t;

   int    vectors     = 0;
   int    miscompares = 0;
   int    cycle       = 0;
   int    req_hs_cyc  = -1;
   bit    bp_mode     = 1'b0;
   beat_t exp_q[$];
   beat_t acc_log[$];

   always @(posedge clk) cycle <= cycle + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail_timeout(input string name);
      vectors++;
      miscompares++;
      $display("FAIL %s: timed out waiting for the DUT (t=%0t)", name, $time);
   endtask

   // ---------------- reference model (closed form per beat) ----------------
   function automatic bit model_err(input req_t r);
      bit [31:0] nb, al0;
      nb  = 32'd1 << r.size;
      al0 = r.addr & ~(nb - 32'd1);
      if (r.burst == 3 || nb > 32'd8) return 1'b1;
      case (r.burst)
         0:       return r.len > 15;
         2:       return !(r.len inside {1, 3, 7, 15}) || (r.addr != al0);
         default: return (r.addr >> 12) != ((al0 + nb * 32'(r.len)) >> 12);
      endcase
   endfunction

   function automatic beat_t model_beat(input req_t r, input int i);
      beat_t     b;
      bit [31:0] nb, al0, total, lower, a, al;
      nb         = 32'd1 << r.size;
      al0        = r.addr & ~(nb - 32'd1);
      b.err      = model_err(r);
      b.addr_chk = 1'b1;
      case (r.burst)
         0: a = r.addr;
         1: a = (i == 0) ? r.addr : al0 + nb * 32'(i);
         2: begin
            total      = nb * 32'(r.len + 1);
            lower      = r.addr - (r.addr % total);
            a          = (i == 0) ? r.addr : lower + ((al0 - lower + nb * 32'(i)) % total);
            b.addr_chk = !b.err;
         end
         default: begin
            a          = r.addr;
            b.addr_chk = 1'b0;
         end
      endcase
      b.addr = a;
      b.strb = '0;
      if (!b.err) begin
         al = a & ~(nb - 32'd1);
         for (int k = 0; k < 8; k++)
            if (32'(k) >= a % 32'd8 && 32'(k) < al % 32'd8 + nb) b.strb[k] = 1'b1;
      end
      b.idx  = i;
      b.last = (i == r.len);
      b.id   = r.id;
      b.cyc  = 0;
      return b;
   endfunction

   // ---------------- beat ready driver ----------------
   always @(posedge clk) begin
      #1;
      bus.beat_ready_i = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // ---------------- compare process ----------------
   int    n;
   beat_t e, c, prv;
   bit    prv_stall = 1'b0;
   req_t  rq;

   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         prv_stall = 1'b0;
      end else begin
         n = exp_q.size();
         check("beat_valid", bus.beat_valid_o, n > 0);
         check("req_ready", bus.req_ready_o, (n == 0) || (n == 1 && bus.beat_ready_i));
         if (n > 0 && bus.beat_valid_o) begin
            e = exp_q[0];
            check("beat_idx",  bus.beat_idx_o,  e.idx);
            check("beat_id",   bus.beat_id_o,   e.id);
            check("beat_last", bus.beat_last_o, e.last);
            check("beat_err",  bus.beat_err_o,  e.err);
            check("beat_strb", bus.beat_strb_o, e.strb);
            if (e.addr_chk) check("beat_addr", bus.beat_addr_o, e.addr);
            if (prv_stall) begin
               check("stall_addr", bus.beat_addr_o, prv.addr);
               check("stall_strb", bus.beat_strb_o, prv.strb);
               check("stall_idx",  bus.beat_idx_o,  prv.idx);
            end
            c.addr = bus.beat_addr_o;
            c.strb = bus.beat_strb_o;
            c.idx  = int'(bus.beat_idx_o);
            c.last = bus.beat_last_o;
            c.err  = bus.beat_err_o;
            c.id   = bus.beat_id_o;
            c.addr_chk = 1'b1;
            c.cyc  = cycle;
            prv    = c;
            if (bus.beat_ready_i) begin
               acc_log.push_back(c);
               void'(exp_q.pop_front());
            end
         end
         prv_stall = bus.beat_valid_o && !bus.beat_ready_i;
         if (bus.req_valid_i && bus.req_ready_o) begin
            rq.addr  = bus.req_addr_i;
            rq.len   = int'(bus.req_len_i);
            rq.size  = int'(bus.req_size_i);
            rq.burst = int'(bus.req_burst_i);
            rq.id    = bus.req_id_i;
            req_hs_cyc = cycle;
            for (int i = 0; i <= rq.len; i++) exp_q.push_back(model_beat(rq, i));
         end
      end
   end

   // ---------------- request driver helpers ----------------
   task automatic send_req(input req_t r);
      int waited = 0;
      bus.req_id_i    = r.id;
      bus.req_addr_i  = r.addr;
      bus.req_len_i   = 8'(r.len);
      bus.req_size_i  = 3'(r.size);
      bus.req_burst_i = axi_burst_type'(2'(r.burst));
      bus.req_valid_i = 1'b1;
      forever begin
         @(negedge clk);
         if (bus.req_ready_o) break;
         waited++;
         if (waited > 2000) begin
            fail_timeout("req_accept");
            break;
         end
      end
      @(posedge clk); #1;
      bus.req_valid_i = 1'b0;
   endtask

   task automatic wait_idle();
      int waited = 0;
      forever begin
         @(posedge clk); #1;
         if (exp_q.size() == 0 && !bus.beat_valid_o) break;
         waited++;
         if (waited > 4000) begin
            fail_timeout("wait_idle");
            break;
         end
      end
   endtask

   task automatic expect_beat(input string tag, input int k, input bit chk_addr,
                              input logic [31:0] addr, input logic [7:0] strb,
                              input logic last, input logic err);
      if (k >= acc_log.size()) begin
         vectors++;
         miscompares++;
         $display("FAIL %s: beat %0d missing, only %0d seen", tag, k, acc_log.size());
      end else begin
         if (chk_addr) check({tag, "_addr"}, acc_log[k].addr, addr);
         check({tag, "_strb"}, acc_log[k].strb, strb);
         check({tag, "_last"}, acc_log[k].last, last);
         check({tag, "_err"},  acc_log[k].err,  err);
      end
   endtask

   function automatic req_t mk(input bit [31:0] a, input int l, input int s, input int b, input bit [3:0] id);
      req_t r;
      r.addr = a; r.len = l; r.size = s; r.burst = b; r.id = id;
      return r;
   endfunction

   // ---------------- watchdog ----------------
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   int    base;
   req_t  r;
   beat_t mb;

   initial begin
      bus.req_valid_i = 1'b0;
      bus.req_id_i    = '0;
      bus.req_addr_i  = '0;
      bus.req_len_i   = '0;
      bus.req_size_i  = '0;
      bus.req_burst_i = AXI_BURST_FIXED;

      // Pin the model against hand-computed values.
      mb = model_beat(mk(32'h38, 3, 3, 2, 0), 1);
      check("model_wrap_b1", mb.addr, 32'h20);
      mb = model_beat(mk(32'h38, 3, 3, 2, 0), 3);
      check("model_wrap_b3", mb.addr, 32'h30);
      mb = model_beat(mk(32'h1003, 1, 2, 1, 0), 0);
      check("model_unal_strb", mb.strb, 8'h08);
      check("model_4kb_err", model_err(mk(32'h0FF8, 3, 3, 1, 0)), 1'b1);

      // Reset values.
      @(posedge clk); @(posedge clk);
      @(negedge clk);
      check("rst_ready", bus.req_ready_o,  1'b1);
      check("rst_valid", bus.beat_valid_o, 1'b0);
      check("rst_addr",  bus.beat_addr_o,  32'h0);
      check("rst_strb",  bus.beat_strb_o,  8'h00);
      check("rst_idx",   bus.beat_idx_o,   8'h00);
      check("rst_last",  bus.beat_last_o,  1'b0);
      check("rst_err",   bus.beat_err_o,   1'b0);
      @(posedge clk); #1;
      rst = 1'b0;

      // INCR aligned.
      base = acc_log.size();
      send_req(mk(32'h1000, 3, 2, 1, 4'h1));
      wait_idle();
      expect_beat("incr0", base + 0, 1, 32'h1000, 8'h0F, 0, 0);
      expect_beat("incr1", base + 1, 1, 32'h1004, 8'hF0, 0, 0);
      expect_beat("incr2", base + 2, 1, 32'h1008, 8'h0F, 0, 0);
      expect_beat("incr3", base + 3, 1, 32'h100C, 8'hF0, 1, 0);

      // WRAP.
      base = acc_log.size();
      send_req(mk(32'h38, 3, 3, 2, 4'h2));
      wait_idle();
      expect_beat("wrap0", base + 0, 1, 32'h38, 8'hFF, 0, 0);
      expect_beat("wrap1", base + 1, 1, 32'h20, 8'hFF, 0, 0);
      expect_beat("wrap2", base + 2, 1, 32'h28, 8'hFF, 0, 0);
      expect_beat("wrap3", base + 3, 1, 32'h30, 8'hFF, 1, 0);

      // Unaligned INCR.
      base = acc_log.size();
      send_req(mk(32'h1003, 1, 2, 1, 4'h3));
      wait_idle();
      expect_beat("unal0", base + 0, 1, 32'h1003, 8'h08, 0, 0);
      expect_beat("unal1", base + 1, 1, 32'h1004, 8'hF0, 1, 0);

      // Illegal: 4KB crossing, WRAP len 2, reserved burst type.
      base = acc_log.size();
      send_req(mk(32'h0FF8, 3, 3, 1, 4'h4));
      wait_idle();
      expect_beat("x4k0", base + 0, 1, 32'h0FF8, 8'h00, 0, 1);
      expect_beat("x4k3", base + 3, 1, 32'h1010, 8'h00, 1, 1);
      check("x4k_beats", acc_log.size() - base, 4);
      base = acc_log.size();
      send_req(mk(32'h0, 2, 2, 2, 4'h5));
      wait_idle();
      expect_beat("wl2_2", base + 2, 0, 32'h0, 8'h00, 1, 1);
      check("wl2_beats", acc_log.size() - base, 3);
      base = acc_log.size();
      send_req(mk(32'h80, 0, 2, 3, 4'h6));
      wait_idle();
      expect_beat("rsvd0", base + 0, 0, 32'h0, 8'h00, 1, 1);

      // FIXED under backpressure, next request taken on the last-beat handshake.
      bp_mode = 1'b1;
      base = acc_log.size();
      send_req(mk(32'h40, 2, 1, 0, 4'h7));
      send_req(mk(32'h2000, 1, 3, 1, 4'h8));
      wait_idle();
      bp_mode = 1'b0;
      expect_beat("fix0", base + 0, 1, 32'h40, 8'h03, 0, 0);
      expect_beat("fix1", base + 1, 1, 32'h40, 8'h03, 0, 0);
      expect_beat("fix2", base + 2, 1, 32'h40, 8'h03, 1, 0);
      expect_beat("b2b0", base + 3, 1, 32'h2000, 8'hFF, 0, 0);
      if (acc_log.size() > base + 2)
         check("b2b_same_cycle", req_hs_cyc, acc_log[base + 2].cyc);

      // Reset in the middle of an 8-beat INCR.
      base = acc_log.size();
      send_req(mk(32'h3000, 7, 2, 1, 4'h9));
      for (int w = 0; w < 100 && acc_log.size() < base + 2; w++) begin
         @(posedge clk); #1;
      end
      check("rst_mid_idx", bus.beat_idx_o, 8'd2);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_mid_valid", bus.beat_valid_o, 1'b0);
      check("rst_mid_ready", bus.req_ready_o,  1'b1);
      base = acc_log.size();
      send_req(mk(32'h3000, 1, 2, 1, 4'hA));
      wait_idle();
      if (acc_log.size() > base) check("post_rst_idx", acc_log[base].idx, 0);
      expect_beat("post_rst0", base + 0, 1, 32'h3000, 8'h0F, 0, 0);

      // Randomized bursts, mixed backpressure, back-to-back issue.
      for (int t = 0; t < 150; t++) begin
         r.id    = 4'($urandom);
         r.burst = $urandom_range(0, 9);
         r.burst = (r.burst < 3) ? 0 : (r.burst < 6) ? 1 : (r.burst < 9) ? 2 : 3;
         r.size  = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 3) : $urandom_range(4, 7);
         if (r.burst == 2 && $urandom_range(0, 3) != 0)
            r.len = (2 << $urandom_range(0, 3)) - 1;
         else
            r.len = $urandom_range(0, 17);
         r.addr = $urandom;
         if ($urandom_range(0, 3) == 0) r.addr[11:8] = 4'hF;
         if ($urandom_range(0, 1) == 1) r.addr = r.addr & ~((32'd1 << r.size) - 32'd1);
         bp_mode = 1'($urandom_range(0, 1));
         send_req(r);
      end
      wait_idle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
